// File: rtl/gpr_wr_arbiter.sv
// gpr_wr_arbiter
//   Arbitrates the single GPR write port between the datapath writeback (req0)
//   and the multi-cycle mul/div unit (req1). The grant is combinational and is
//   returned as reqN_ready. The winning write is registered onto GPRWr/rw/WD,
//   which drive the register file directly.
//   A pending bit per register marks destinations of mul/div ops in flight.
//   req0 is held off on a pending destination so its write cannot be
//   overtaken by an older mul/div result.
//   rs_busy/rt_busy flag a source operand that is pending, or that is being
//   written this cycle.
// Ports
//   clk, rst                 clock; asynchronous active-high reset
//   req0_valid/rw/wd, ready  datapath writeback request and its grant
//   req1_valid/rw/wd, ready  mul/div writeback request and its grant
//   issue_valid, issue_rw    mul/div launch; marks issue_rw pending
//   rs, rt -> rs_busy/rt_busy  source-operand hazard flags (combinational)
//   GPRWr, rw, WD            registered GPR write port
module gpr_wr_arbiter #(
  parameter int DW    = 32,
  parameter int AW    = 5,
  parameter int RR_EN = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  input  logic [AW-1:0] req0_rw,
  input  logic [DW-1:0] req0_wd,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [AW-1:0] req1_rw,
  input  logic [DW-1:0] req1_wd,
  output logic          req1_ready,
  input  logic          issue_valid,
  input  logic [AW-1:0] issue_rw,
  input  logic [AW-1:0] rs,
  input  logic [AW-1:0] rt,
  output logic          rs_busy,
  output logic          rt_busy,
  output logic          GPRWr,
  output logic [AW-1:0] rw,
  output logic [DW-1:0] WD
);

  localparam int NREG = 1 << AW;

  logic [NREG-1:0] pending_q, pending_d;
  logic            last_grant_q, last_grant_d;  // 0 = req0, 1 = req1
  logic            gpr_wr_q, gpr_wr_d;
  logic [AW-1:0]   rw_q, rw_d;
  logic [DW-1:0]   wd_q, wd_d;
  logic            elig0, elig1, grant0, grant1;

  // Grant. A grant is only ever given to a valid requester, so a grant is
  // also the handshake.
  always_comb begin
    elig0  = req0_valid && !(pending_q[req0_rw] && (req0_rw != '0));
    elig1  = req1_valid;
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (elig0 && elig1) begin
      // Round-robin picks the side that did not win last time.
      if ((RR_EN != 0) && !last_grant_q) grant1 = 1'b1;
      else                               grant0 = 1'b1;
    end else begin
      grant0 = elig0;
      grant1 = elig1;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Next state for the write port, the arbiter history and the pending bits.
  always_comb begin
    last_grant_d = last_grant_q;
    gpr_wr_d     = 1'b0;
    rw_d         = rw_q;
    wd_d         = wd_q;
    pending_d    = pending_q;
    if (grant0) begin
      last_grant_d = 1'b0;
      gpr_wr_d     = (req0_rw != '0);
      rw_d         = req0_rw;
      wd_d         = req0_wd;
    end else if (grant1) begin
      last_grant_d = 1'b1;
      gpr_wr_d     = (req1_rw != '0);
      rw_d         = req1_rw;
      wd_d         = req1_wd;
      pending_d[req1_rw] = 1'b0;
    end
    // The set is applied after the clear, so a new issue wins over a
    // retirement to the same register in the same cycle.
    if (issue_valid && (issue_rw != '0)) pending_d[issue_rw] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q    <= '0;
      last_grant_q <= 1'b1;
      gpr_wr_q     <= 1'b0;
      rw_q         <= '0;
      wd_q         <= '0;
    end else begin
      pending_q    <= pending_d;
      last_grant_q <= last_grant_d;
      gpr_wr_q     <= gpr_wr_d;
      rw_q         <= rw_d;
      wd_q         <= wd_d;
    end
  end

  assign GPRWr = gpr_wr_q;
  assign rw    = rw_q;
  assign WD    = wd_q;

  // Busy covers the commit cycle as well. The register file is only updated
  // at the end of the GPRWr cycle, so a read in that cycle would see stale data.
  assign rs_busy = (rs != '0) && (pending_q[rs] || (gpr_wr_q && (rw_q == rs)));
  assign rt_busy = (rt != '0) && (pending_q[rt] || (gpr_wr_q && (rw_q == rt)));

endmodule

// File: tb/tb_gpr_wr_arbiter.sv
// Testbench for gpr_wr_arbiter. The stimulus pushes each expected register
// write (commit cycle, address, data) when it grants; a monitor process pops
// and compares on every GPRWr pulse. A second instance with RR_EN=0 shares
// the same inputs.
module tb_gpr_wr_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req0_valid, req1_valid, issue_valid;
  logic [AW-1:0] req0_rw, req1_rw, issue_rw, rs, rt;
  logic [DW-1:0] req0_wd, req1_wd;
  logic          req0_ready, req1_ready, rs_busy, rt_busy, gpr_wr;
  logic [AW-1:0] rw;
  logic [DW-1:0] wd;
  logic          fp_req0_ready, fp_req1_ready, fp_rs_busy, fp_rt_busy, fp_gpr_wr;
  logic [AW-1:0] fp_rw;
  logic [DW-1:0] fp_wd;

  gpr_wr_arbiter #(.DW(DW), .AW(AW), .RR_EN(1)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_rw(req0_rw), .req0_wd(req0_wd), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_rw(req1_rw), .req1_wd(req1_wd), .req1_ready(req1_ready),
    .issue_valid(issue_valid), .issue_rw(issue_rw), .rs(rs), .rt(rt),
    .rs_busy(rs_busy), .rt_busy(rt_busy), .GPRWr(gpr_wr), .rw(rw), .WD(wd)
  );

  gpr_wr_arbiter #(.DW(DW), .AW(AW), .RR_EN(0)) dut_fp (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_rw(req0_rw), .req0_wd(req0_wd), .req0_ready(fp_req0_ready),
    .req1_valid(req1_valid), .req1_rw(req1_rw), .req1_wd(req1_wd), .req1_ready(fp_req1_ready),
    .issue_valid(issue_valid), .issue_rw(issue_rw), .rs(rs), .rt(rt),
    .rs_busy(fp_rs_busy), .rt_busy(fp_rt_busy), .GPRWr(fp_gpr_wr), .rw(fp_rw), .WD(fp_wd)
  );

  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  typedef struct {
    int            cyc;
    logic [AW-1:0] rw;
    logic [DW-1:0] wd;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Check the grant and record the write it should produce next cycle.
  task automatic grant(input string name, input logic g0, input logic g1);
    exp_t e;
    chk({name, "_req0_ready"}, req0_ready, g0);
    chk({name, "_req1_ready"}, req1_ready, g1);
    if (g0 && req0_rw != '0) begin
      e.cyc = cyc_cnt + 1; e.rw = req0_rw; e.wd = req0_wd; sb.push_back(e);
    end
    if (g1 && req1_rw != '0) begin
      e.cyc = cyc_cnt + 1; e.rw = req1_rw; e.wd = req1_wd; sb.push_back(e);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (gpr_wr) begin
          if (sb.size() == 0) chk("unexpected_GPRWr", gpr_wr, 0);
          else begin
            e = sb.pop_front();
            chk("wr_cycle", cyc_cnt, e.cyc);
            chk("wr_rw", rw, e.rw);
            chk("wr_WD", wd, e.wd);
          end
        end else if (sb.size() != 0 && sb[0].cyc <= cyc_cnt) begin
          e = sb.pop_front();
          chk("missing_GPRWr", gpr_wr, 1);
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req0_valid = 0; req1_valid = 0; issue_valid = 0;
  endtask

  task automatic set0(input logic [AW-1:0] r, input logic [DW-1:0] d);
    req0_valid = 1; req0_rw = r; req0_wd = d;
  endtask

  task automatic set1(input logic [AW-1:0] r, input logic [DW-1:0] d);
    req1_valid = 1; req1_rw = r; req1_wd = d;
  endtask

  task automatic issue(input logic [AW-1:0] r);
    issue_valid = 1; issue_rw = r;
  endtask

  initial begin
    idle();
    req0_rw = 0; req1_rw = 0; issue_rw = 0; req0_wd = 0; req1_wd = 0;
    rs = 0; rt = 0;
    fork monitor(); join_none
    #1 rst = 1;
    #1;
    chk("rst_GPRWr", gpr_wr, 0);
    chk("rst_rw", rw, 0);
    chk("rst_WD", wd, 0);
    tick(); tick();
    rst = 0;

    // T2: single req0 write, in-flight busy, then idle
    tick(); set0(5, 32'h1234); #2; grant("t2", 1, 0);
    tick(); idle(); rs = 5; #2; grant("t2_idle", 0, 0); chk("t2_rs_busy_inflight", rs_busy, 1);
    tick(); #2; chk("t2_rs_busy_after", rs_busy, 0);

    // T3: contention; last grant was req0, so round-robin starts with req1
    for (int i = 0; i < 4; i++) begin
      tick(); set0(3, 32'h100 + i); set1(4, 32'h200 + i); #2;
      grant($sformatf("t3_rr%0d", i), (i % 2) == 1, (i % 2) == 0);
      chk($sformatf("t3_fp%0d_req0", i), fp_req0_ready, 1);
      chk($sformatf("t3_fp%0d_req1", i), fp_req1_ready, 0);
    end
    tick(); idle(); rs = 0;

    // T4: pending register blocks req0 until req1 retires it
    tick(); issue(7); #2; grant("t4_issue", 0, 0);
    tick(); idle(); rs = 7; rt = 7; set0(7, 32'hAA); #2;
    grant("t4_blk", 0, 0); chk("t4_rs_busy", rs_busy, 1); chk("t4_rt_busy", rt_busy, 1);
    tick(); set1(7, 32'hBB); #2; grant("t4_ret", 0, 1); chk("t4_rs_busy_pend", rs_busy, 1);
    tick(); idle(); #2; grant("t4_idle", 0, 0); chk("t4_rs_busy_inflight", rs_busy, 1);
    tick(); #2; chk("t4_rs_busy_clear", rs_busy, 0); chk("t4_rt_busy_clear", rt_busy, 0);
    set0(7, 32'hAC); #1; grant("t4_unblk", 1, 0);
    tick(); idle(); rs = 0; rt = 0;

    // T5: issue and retire to r9 in the same cycle -> stays pending
    tick(); issue(9);
    tick(); issue(9); set1(9, 32'h99); #2; grant("t5_coll", 0, 1);
    tick(); idle(); rs = 9; #2; chk("t5_rs_busy_a", rs_busy, 1);
    tick(); set0(9, 32'h9A); #2; grant("t5_blk", 0, 0); chk("t5_rs_busy_pend", rs_busy, 1);
    tick(); set1(9, 32'h98); #2; grant("t5_ret", 0, 1);
    tick(); req1_valid = 0; #2; grant("t5_unblk", 1, 0);
    tick(); idle(); rs = 0;

    // T6: r0 handshakes but never writes; issue to r0 ignored
    tick(); set1(0, 32'h55); issue(0); #2; grant("t6_r0", 0, 1); chk("t6_rs_busy", rs_busy, 0);
    tick(); idle(); #2;
    chk("t6_GPRWr", gpr_wr, 0); chk("t6_rw", rw, 0); chk("t6_WD", wd, 32'h55);
    chk("t6_rs_busy2", rs_busy, 0);

    // T1: reset mid-cycle drops the in-flight write and clears pending
    tick(); issue(10);
    tick(); idle(); set0(6, 32'h66); #2; grant("t1_wr", 1, 0);
    tick(); idle(); rs = 10; rt = 6; #1;
    chk("t1_rs_busy_pre", rs_busy, 1); chk("t1_rt_busy_pre", rt_busy, 1);
    rst = 1; #1;
    sb.delete();
    chk("t1_GPRWr", gpr_wr, 0); chk("t1_rw", rw, 0); chk("t1_WD", wd, 0);
    chk("t1_rs_busy", rs_busy, 0); chk("t1_rt_busy", rt_busy, 0);
    tick(); rst = 0;
    // After reset round-robin favours req0 first
    tick(); set0(3, 32'h300); set1(4, 32'h400); #2; grant("t1_rr0", 1, 0);
    tick(); set0(3, 32'h301); #2; grant("t1_rr1", 0, 1);
    tick(); idle(); rs = 0; rt = 0;
    tick(); tick(); tick();
    chk("sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
